// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD time writer: FSM states, ASCII codes,
// the set-DDRAM instruction base and the BCD time snapshot layout.
package lcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_RDY
    } state_t;

    localparam logic [7:0] CH_ZERO       = 8'h30;
    localparam logic [7:0] CH_COLON      = 8'h3A;
    localparam logic [7:0] CH_SPACE      = 8'h20;
    localparam logic [7:0] CH_QMARK      = 8'h3F;
    localparam logic [7:0] INS_SET_DDRAM = 8'h80;
    localparam logic [3:0] LAST_IDX      = 4'd8;

    typedef struct packed {
        logic [3:0] hh_t;
        logic [3:0] hh_u;
        logic [3:0] mm_t;
        logic [3:0] mm_u;
        logic [3:0] ss_t;
        logic [3:0] ss_u;
    } bcd_time_t;

endpackage

// File: rtl/bcd_to_ascii.sv
// Combinational BCD digit to ASCII character; non-decimal codes show as '?'.
module bcd_to_ascii
    import lcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] ascii
);

    assign ascii = (digit > 4'd9) ? CH_QMARK : (CH_ZERO + {4'd0, digit});

endmodule

// File: rtl/lcd_time_writer.sv
// Writes a snapshot of the BCD time to a character LCD as "HH:MM:SS" (address
// instruction + 8 characters). Build option LCD_TIME_BLINK_EN blanks colons on odd seconds.
module lcd_time_writer
    import lcd_pkg::*;
#(
    parameter logic [6:0] LCD_ADDR = 7'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       update,
    input  logic [3:0] hh_t,
    input  logic [3:0] hh_u,
    input  logic [3:0] mm_t,
    input  logic [3:0] mm_u,
    input  logic [3:0] ss_t,
    input  logic [3:0] ss_u,
    input  logic       lcd_ready,
    output logic [7:0] lcd_data,
    output logic       lcd_ins_data,
    output logic       lcd_send,
    output logic       busy,
    output logic       done,
    output state_t     dbg_state
);

    // Handshake: lcd_send is a one-cycle request issued only after lcd_ready was
    // sampled high; the interface accepts by dropping lcd_ready and signals
    // completion by raising it again. Data/RS hold until the next request.

    state_t     state, state_n;
    logic [3:0] idx, idx_n;
    logic       pending, pending_n;
    bcd_time_t  snap, snap_n, live;
    logic [7:0] data_n;
    logic       ins_n, send_n, busy_n, done_n;
    logic [3:0] digit;
    logic [7:0] digit_ascii, colon, cur_byte;

    assign live = {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u};

    always_comb begin
        digit = 4'd0;
        case (idx)
            4'd1:    digit = snap.hh_t;
            4'd2:    digit = snap.hh_u;
            4'd4:    digit = snap.mm_t;
            4'd5:    digit = snap.mm_u;
            4'd7:    digit = snap.ss_t;
            4'd8:    digit = snap.ss_u;
            default: digit = 4'd0;
        endcase
    end

    bcd_to_ascii u_enc (
        .digit (digit),
        .ascii (digit_ascii)
    );

`ifdef LCD_TIME_BLINK_EN
    assign colon = snap.ss_u[0] ? CH_SPACE : CH_COLON;
`else
    assign colon = CH_COLON;
`endif

    always_comb begin
        cur_byte = digit_ascii;
        if (idx == 4'd0) begin
            cur_byte = INS_SET_DDRAM | {1'b0, LCD_ADDR};
        end else if (idx == 4'd3 || idx == 4'd6) begin
            cur_byte = colon;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        pending_n = pending;
        snap_n    = snap;
        data_n    = lcd_data;
        ins_n     = lcd_ins_data;
        send_n    = 1'b0;
        busy_n    = busy;
        done_n    = 1'b0;
        if (busy && update) begin
            pending_n = 1'b1;
        end
        case (state)
            IDLE: begin
                if (update) begin
                    snap_n  = live;
                    idx_n   = 4'd0;
                    busy_n  = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (lcd_ready) begin
                    data_n  = cur_byte;
                    ins_n   = (idx != 4'd0);
                    send_n  = 1'b1;
                    state_n = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!lcd_ready) begin
                    state_n = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (lcd_ready) begin
                    if (idx < LAST_IDX) begin
                        idx_n   = idx + 4'd1;
                        state_n = SEND;
                    end else begin
                        done_n    = 1'b1;
                        pending_n = 1'b0;
                        // A request arriving in the completion cycle is treated like a pending one.
                        if (pending || update) begin
                            snap_n  = live;
                            idx_n   = 4'd0;
                            state_n = SEND;
                        end else begin
                            busy_n  = 1'b0;
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            idx          <= 4'd0;
            pending      <= 1'b0;
            snap         <= '0;
            lcd_data     <= 8'h00;
            lcd_ins_data <= 1'b0;
            lcd_send     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            pending      <= pending_n;
            snap         <= snap_n;
            lcd_data     <= data_n;
            lcd_ins_data <= ins_n;
            lcd_send     <= send_n;
            busy         <= busy_n;
            done         <= done_n;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_lcd_time_writer.sv
// Self-checking bench for lcd_time_writer: a reference model turns each requested
// time into the expected transfer list; a ready/acknowledge model answers every send.
module tb_lcd_time_writer;
  import lcd_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       update;
  logic [3:0] hh_t, hh_u, mm_t, mm_u, ss_t, ss_u;
  logic       lcd_ready;
  logic [7:0] lcd_data;
  logic       lcd_ins_data;
  logic       lcd_send;
  logic       busy;
  logic       done;
  state_t     dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] exp_q[$];

  int   send_cnt = 0;
  int   done_cnt = 0;
  int   lat_cnt = 0;
  int   lat_cfg = 3;
  logic hold_low = 1'b0;
  logic prev_send = 1'b0;
  logic busy_at_done = 1'b0;

  always #5 clk = ~clk;

  assign lcd_ready = (lat_cnt == 0) && !hold_low;

  lcd_time_writer dut (
    .clk          (clk),
    .rst          (rst),
    .update       (update),
    .hh_t         (hh_t),
    .hh_u         (hh_u),
    .mm_t         (mm_t),
    .mm_u         (mm_u),
    .ss_t         (ss_t),
    .ss_u         (ss_u),
    .lcd_ready    (lcd_ready),
    .lcd_data     (lcd_data),
    .lcd_ins_data (lcd_ins_data),
    .lcd_send     (lcd_send),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] enc(input logic [3:0] d);
    return (d <= 4'd9) ? 8'h30 + {4'h0, d} : 8'h3F;
  endfunction

  // Expected transfers for the time currently on the digit inputs.
  task automatic push_line();
    logic [7:0] colon;
    colon = 8'h3A;
`ifdef LCD_TIME_BLINK_EN
    if (ss_u[0]) colon = 8'h20;
`endif
    exp_q.push_back({1'b0, 8'h80});
    exp_q.push_back({1'b1, enc(hh_t)});
    exp_q.push_back({1'b1, enc(hh_u)});
    exp_q.push_back({1'b1, colon});
    exp_q.push_back({1'b1, enc(mm_t)});
    exp_q.push_back({1'b1, enc(mm_u)});
    exp_q.push_back({1'b1, colon});
    exp_q.push_back({1'b1, enc(ss_t)});
    exp_q.push_back({1'b1, enc(ss_u)});
  endtask

  // Interface model and scoreboard: every send is popped against exp_q.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (lcd_send) begin
        send_cnt++;
        check("send_while_ready_low", 32'(lcd_ready), 32'd1);
        check("send_back_to_back", 32'(prev_send), 32'd0);
        check("send_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check("byte", 32'({lcd_ins_data, lcd_data}), 32'(exp_q.pop_front()));
        end
      end
      if (done) begin
        done_cnt++;
        busy_at_done = busy;
      end
      prev_send = lcd_send;
      if (lat_cnt > 0) lat_cnt--;
      if (lcd_send) lat_cnt = lat_cfg;
    end
  end

  task automatic set_time(input logic [3:0] a, b, c, d, e, f);
    hh_t = a; hh_u = b; mm_t = c; mm_u = d; ss_t = e; ss_u = f;
  endtask

  task automatic pulse_update();
    @(negedge clk);
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      #3;
      n++;
    end
    check("done_count", 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_sends(input int target, input int budget);
    int n;
    n = 0;
    while (send_cnt < target && n < budget) begin
      @(posedge clk);
      #3;
      n++;
    end
    check("send_reached", 32'(send_cnt >= target), 32'd1);
  endtask

  task automatic run_line(input string tag);
    int d0;
    d0 = done_cnt;
    push_line();
    pulse_update();
    wait_done(d0 + 1, 400);
    check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int s0, d0;
    update = 1'b0;
    set_time(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #2 rst = 1'b0;
    #3;
    check("rst_send", 32'(lcd_send), 32'd0);
    check("rst_data", 32'(lcd_data), 32'd0);
    check("rst_ins", 32'(lcd_ins_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // 12:34:56 with a 3-cycle ready-low answer; first send two cycles after update
    set_time(1, 2, 3, 4, 5, 6);
    lat_cfg = 3;
    push_line();
    d0 = done_cnt;
    @(negedge clk);
    update = 1'b1;
    @(posedge clk);
    #2;
    update = 1'b0;
    check("busy_after_update", 32'(busy), 32'd1);
    check("no_send_t1", 32'(lcd_send), 32'd0);
    @(posedge clk);
    #2;
    check("send_at_t2", 32'(lcd_send), 32'd1);
    wait_done(d0 + 1, 400);
    check("busy_drops_with_done", 32'(busy_at_done), 32'd0);
    repeat (5) @(posedge clk);
    #3;
    check("done_exactly_once", 32'(done_cnt), 32'(d0 + 1));
    check("line1_drained", 32'(exp_q.size()), 32'd0);

    // Ready held low: nothing is sent until it rises
    hold_low = 1'b1;
    push_line();
    s0 = send_cnt;
    d0 = done_cnt;
    pulse_update();
    repeat (100) @(posedge clk);
    #2;
    check("no_send_ready_low", 32'(send_cnt), 32'(s0));
    check("busy_while_held", 32'(busy), 32'd1);
    hold_low = 1'b0;
    @(posedge clk);
    #2;
    check("send_on_first_ready", 32'(lcd_send), 32'd1);
    check("addr_on_first_ready", 32'(lcd_data), 32'h80);
    wait_done(d0 + 1, 400);

    // Update during char 4 (merged twice) queues exactly one more line
    set_time(1, 2, 3, 4, 5, 6);
    push_line();
    s0 = send_cnt;
    d0 = done_cnt;
    pulse_update();
    wait_sends(s0 + 5, 400);
    set_time(1, 2, 3, 4, 5, 7);
    push_line();
    pulse_update();
    repeat (3) @(posedge clk);
    pulse_update();
    wait_done(d0 + 1, 400);
    check("busy_held_at_pending_done", 32'(busy_at_done), 32'd1);
    wait_done(d0 + 2, 400);
    check("busy_drops_after_second", 32'(busy_at_done), 32'd0);
    repeat (5) @(posedge clk);
    #3;
    check("pending_single_extra", 32'(done_cnt), 32'(d0 + 2));
    check("pending_drained", 32'(exp_q.size()), 32'd0);

    // Out-of-range tens-of-hours digit
    set_time(4'hB, 2, 3, 4, 5, 6);
    run_line("qmark");

    // Odd and even seconds (colon blanking only in the blink build)
    set_time(1, 2, 3, 4, 5, 7);
    run_line("ss57");
    set_time(1, 2, 3, 4, 5, 8);
    run_line("ss58");

    // Asynchronous reset in WAIT_RDY of char 5, then a clean full line
    set_time(2, 3, 5, 9, 0, 1);
    push_line();
    s0 = send_cnt;
    pulse_update();
    wait_sends(s0 + 6, 400);
    begin
      int n;
      n = 0;
      while (dbg_state != WAIT_RDY && n < 50) begin
        @(posedge clk);
        #3;
        n++;
      end
      check("reach_wait_rdy", 32'(dbg_state), 32'(WAIT_RDY));
    end
    rst = 1'b0;
    #1;
    check("async_rst_send", 32'(lcd_send), 32'd0);
    check("async_rst_data", 32'(lcd_data), 32'd0);
    check("async_rst_ins", 32'(lcd_ins_data), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_state", 32'(dbg_state), 32'(IDLE));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    s0 = send_cnt;
    run_line("after_rst");
    check("after_rst_nine_sends", 32'(send_cnt - s0), 32'd9);

    // Randomized times and interface latencies
    for (int i = 0; i < 8; i++) begin
      logic [3:0] d[6];
      for (int k = 0; k < 6; k++) begin
        d[k] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      lat_cfg = $urandom_range(1, 5);
      set_time(d[0], d[1], d[2], d[3], d[4], d[5]);
      run_line("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
